// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and MEM-side training signals of the branch predictor.
// The master is the pipeline (or bench), the slave is the predictor.
interface branch_predictor_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] if_pc;
  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_target;
  logic                  update_en;
  logic [DATA_WIDTH-1:0] update_pc;
  logic                  update_taken;
  logic [DATA_WIDTH-1:0] update_target;
  logic                  update_pred_taken;
  logic [DATA_WIDTH-1:0] update_pred_target;
  logic                  mispredict;
  logic [CNT_WIDTH-1:0]  branch_count;
  logic [CNT_WIDTH-1:0]  mispredict_count;

  modport master (
    output if_pc, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    input  pred_taken, pred_target, mispredict, branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    output pred_taken, pred_target, mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry, trained from
// MEM-stage branch resolution, plus saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_BITS   = 4,
  parameter int CNT_WIDTH  = 32
) (
  input logic               clk,
  input logic               rstn,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = DATA_WIDTH - IDX_BITS - 2;

  logic [ENTRIES-1:0]    r_valid;
  logic [1:0]            r_ctr    [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [ENTRIES];

  logic [CNT_WIDTH-1:0]  r_branch_count;
  logic [CNT_WIDTH-1:0]  r_mispredict_count;

  logic [IDX_BITS-1:0]   w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic                  w_if_hit;
  logic                  w_pred_taken;
  logic [DATA_WIDTH-1:0] w_pc_plus4;

  logic [IDX_BITS-1:0]   w_up_idx;
  logic [TAG_W-1:0]      w_up_tag;
  logic                  w_up_hit;
  logic [1:0]            w_ctr_next;
  logic                  w_mispredict;
  logic                  w_bc_full;
  logic                  w_mc_full;

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  assign w_if_idx     = bp.if_pc[IDX_BITS+1:2];
  assign w_if_tag     = bp.if_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];
  assign w_pc_plus4   = bp.if_pc + DATA_WIDTH'(4);

  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_taken ? r_target[w_if_idx] : w_pc_plus4;

  assign w_up_idx = bp.update_pc[IDX_BITS+1:2];
  assign w_up_tag = bp.update_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  assign w_mispredict = bp.update_en &&
                        ((bp.update_pred_taken != bp.update_taken) ||
                         (bp.update_taken &&
                          (bp.update_pred_target != bp.update_target)));
  assign bp.mispredict = w_mispredict;

  always_comb begin
    w_ctr_next = r_ctr[w_up_idx];
    if (bp.update_taken) begin
      if (r_ctr[w_up_idx] != 2'b11) w_ctr_next = r_ctr[w_up_idx] + 2'b01;
    end else begin
      if (r_ctr[w_up_idx] != 2'b00) w_ctr_next = r_ctr[w_up_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else if (bp.update_en) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
      end else if (bp.update_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= 2'b10;
      end
    end
  end

  // A taken update writes tag and target on both hit and allocate; on a hit
  // the tag already matches, so rewriting it is harmless.
  always_ff @(posedge clk) begin
    if (rstn && bp.update_en && bp.update_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= bp.update_target;
    end
  end

  assign w_bc_full = &r_branch_count;
  assign w_mc_full = &r_mispredict_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (bp.update_en && !w_bc_full)
        r_branch_count <= r_branch_count + CNT_WIDTH'(1);
      if (w_mispredict && !w_mc_full)
        r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
    end
  end

  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, counter saturation,
// aliasing, same-cycle lookup/update, PC wrap and mid-run reset.
module tb_branch_predictor;
  localparam int DW = 32;
  localparam int CW = 32;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  branch_predictor_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bp ();

  branch_predictor #(.DATA_WIDTH(DW), .IDX_BITS(4), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bp   (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one resolved branch for exactly one rising edge, then idles.
  task automatic do_update(input logic [DW-1:0] pc, input logic taken,
                           input logic [DW-1:0] target, input logic ptaken,
                           input logic [DW-1:0] ptarget);
    @(negedge clk);
    bp.update_en          = 1'b1;
    bp.update_pc          = pc;
    bp.update_taken       = taken;
    bp.update_target      = target;
    bp.update_pred_taken  = ptaken;
    bp.update_pred_target = ptarget;
    @(negedge clk);
    bp.update_en = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rstn                  = 1'b0;
    bp.if_pc              = 32'h40;
    bp.update_en          = 1'b0;
    bp.update_pc          = '0;
    bp.update_taken       = 1'b0;
    bp.update_target      = '0;
    bp.update_pred_taken  = 1'b1;
    bp.update_pred_target = 32'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_pred_taken got %b exp 0", bp.pred_taken);
    end
    checks++;
    if (bp.pred_target !== 32'h44) begin
      errors++; $display("FAIL reset_pred_target got %h exp 00000044", bp.pred_target);
    end
    checks++;
    if (bp.branch_count !== 32'd0 || bp.mispredict_count !== 32'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bp.branch_count, bp.mispredict_count);
    end
    checks++;
    if (bp.mispredict !== 1'b0) begin
      errors++; $display("FAIL reset_mispredict_idle got %b exp 0", bp.mispredict);
    end
  endtask

  // Allocation for 0x40 with a same-cycle lookup of the same PC.
  task automatic test_allocate;
    @(negedge clk);
    bp.if_pc              = 32'h40;
    bp.update_en          = 1'b1;
    bp.update_pc          = 32'h40;
    bp.update_taken       = 1'b1;
    bp.update_target      = 32'h20;
    bp.update_pred_taken  = 1'b0;
    bp.update_pred_target = 32'h44;
    #1;
    checks++;
    if (bp.mispredict !== 1'b1) begin
      errors++; $display("FAIL alloc_mispredict got %b exp 1", bp.mispredict);
    end
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      errors++; $display("FAIL same_cycle_pre got %b/%h exp 0/00000044", bp.pred_taken, bp.pred_target);
    end
    @(negedge clk);
    bp.update_en = 1'b0;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h20) begin
      errors++; $display("FAIL alloc_lookup got %b/%h exp 1/00000020", bp.pred_taken, bp.pred_target);
    end
    checks++;
    if (bp.branch_count !== 32'd1 || bp.mispredict_count !== 32'd1) begin
      errors++; $display("FAIL alloc_counts got %0d/%0d exp 1/1", bp.branch_count, bp.mispredict_count);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 2; i++) do_update(32'h40, 1'b1, 32'h20, 1'b1, 32'h20);
    checks++;
    if (bp.branch_count !== 32'd3 || bp.mispredict_count !== 32'd1) begin
      errors++; $display("FAIL sat_correct_counts got %0d/%0d exp 3/1", bp.branch_count, bp.mispredict_count);
    end
    do_update(32'h40, 1'b0, 32'h0, 1'b1, 32'h20);
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h20) begin
      errors++; $display("FAIL sat_first_nt got %b/%h exp 1/00000020", bp.pred_taken, bp.pred_target);
    end
    do_update(32'h40, 1'b0, 32'h0, 1'b1, 32'h20);
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      errors++; $display("FAIL sat_second_nt got %b/%h exp 0/00000044", bp.pred_taken, bp.pred_target);
    end
    // Hit with ctr=01 going taken: 01->10 and target refreshed.
    do_update(32'h40, 1'b1, 32'h24, 1'b0, 32'h44);
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h24) begin
      errors++; $display("FAIL hit_retarget got %b/%h exp 1/00000024", bp.pred_taken, bp.pred_target);
    end
    checks++;
    if (bp.branch_count !== 32'd6 || bp.mispredict_count !== 32'd4) begin
      errors++; $display("FAIL sat_counts got %0d/%0d exp 6/4", bp.branch_count, bp.mispredict_count);
    end
  endtask

  task automatic test_aliasing;
    @(negedge clk);
    bp.if_pc = 32'h80;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h84) begin
      errors++; $display("FAIL alias_miss got %b/%h exp 0/00000084", bp.pred_taken, bp.pred_target);
    end
    do_update(32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
    bp.if_pc = 32'h40;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      errors++; $display("FAIL alias_evicted got %b/%h exp 0/00000044", bp.pred_taken, bp.pred_target);
    end
    bp.if_pc = 32'h80;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h100) begin
      errors++; $display("FAIL alias_new got %b/%h exp 1/00000100", bp.pred_taken, bp.pred_target);
    end
    // Not-taken miss on the same index must leave the entry alone.
    do_update(32'hC0, 1'b0, 32'h0, 1'b0, 32'hC4);
    bp.if_pc = 32'h80;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h100) begin
      errors++; $display("FAIL nt_miss_keep got %b/%h exp 1/00000100", bp.pred_taken, bp.pred_target);
    end
    bp.if_pc = 32'hC0;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'hC4) begin
      errors++; $display("FAIL nt_miss_noalloc got %b/%h exp 0/000000c4", bp.pred_taken, bp.pred_target);
    end
    checks++;
    if (bp.branch_count !== 32'd8 || bp.mispredict_count !== 32'd5) begin
      errors++; $display("FAIL alias_counts got %0d/%0d exp 8/5", bp.branch_count, bp.mispredict_count);
    end
  endtask

  // Purely combinational: no clock edge while update_en is raised here.
  task automatic test_mispredict_terms;
    @(negedge clk);
    bp.update_en          = 1'b1;
    bp.update_pc          = 32'h200;
    bp.update_taken       = 1'b1;
    bp.update_pred_taken  = 1'b1;
    bp.update_target      = 32'h304;
    bp.update_pred_target = 32'h300;
    #1;
    checks++;
    if (bp.mispredict !== 1'b1) begin
      errors++; $display("FAIL mp_target_diff got %b exp 1", bp.mispredict);
    end
    bp.update_pred_target = 32'h304;
    #1;
    checks++;
    if (bp.mispredict !== 1'b0) begin
      errors++; $display("FAIL mp_correct got %b exp 0", bp.mispredict);
    end
    bp.update_taken      = 1'b0;
    bp.update_pred_taken = 1'b0;
    bp.update_target     = 32'h500;
    #1;
    checks++;
    if (bp.mispredict !== 1'b0) begin
      errors++; $display("FAIL mp_nt_target_ignored got %b exp 0", bp.mispredict);
    end
    bp.update_pred_taken = 1'b1;
    bp.update_en         = 1'b0;
    #1;
    checks++;
    if (bp.mispredict !== 1'b0) begin
      errors++; $display("FAIL mp_gated got %b exp 0", bp.mispredict);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    bp.if_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
      errors++; $display("FAIL wrap_plus4 got %b/%h exp 0/00000000", bp.pred_taken, bp.pred_target);
    end
    do_update(32'hFFFF_FFFC, 1'b1, 32'h8, 1'b0, 32'h0);
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h8) begin
      errors++; $display("FAIL wrap_trained got %b/%h exp 1/00000008", bp.pred_taken, bp.pred_target);
    end
  endtask

  // 0x80 entry sits at 10: three not-taken reach 00 and stay; one taken gives 01.
  task automatic test_counter_floor;
    for (int i = 0; i < 3; i++) do_update(32'h80, 1'b0, 32'h0, 1'b0, 32'h84);
    do_update(32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
    bp.if_pc = 32'h80;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h84) begin
      errors++; $display("FAIL ctr_floor got %b/%h exp 0/00000084", bp.pred_taken, bp.pred_target);
    end
    checks++;
    if (bp.branch_count !== 32'd13 || bp.mispredict_count !== 32'd7) begin
      errors++; $display("FAIL floor_counts got %0d/%0d exp 13/7", bp.branch_count, bp.mispredict_count);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    rstn                  = 1'b0;
    bp.update_en          = 1'b1;
    bp.update_pc          = 32'h40;
    bp.update_taken       = 1'b1;
    bp.update_target      = 32'h98;
    bp.update_pred_taken  = 1'b0;
    bp.update_pred_target = 32'h44;
    @(negedge clk);
    rstn         = 1'b1;
    bp.update_en = 1'b0;
    bp.if_pc     = 32'h40;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      errors++; $display("FAIL rst_mid_0x40 got %b/%h exp 0/00000044", bp.pred_taken, bp.pred_target);
    end
    bp.if_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
      errors++; $display("FAIL rst_mid_wrap got %b/%h exp 0/00000000", bp.pred_taken, bp.pred_target);
    end
    checks++;
    if (bp.branch_count !== 32'd0 || bp.mispredict_count !== 32'd0) begin
      errors++; $display("FAIL rst_mid_counts got %0d/%0d exp 0/0", bp.branch_count, bp.mispredict_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_allocate();
    test_saturation();
    test_aliasing();
    test_mispredict_terms();
    test_wrap();
    test_counter_floor();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
